mem_set_loader: RTL
===================

Name: mem_set_loader

Overview:
- Board-side writer for the data-memory preset port of the MIPS SoC. It drives MemSet/MemVal/MemNum into the SoC's MEM stage, which is the receiving end.
- Turns raw push-buttons and switches into clean, single-cycle write strobes. Inputs are synchronised and debounced, and operand setup/hold is sequenced around each strobe.
- Supports two addressing modes: manual, where the word index comes from switches, and auto-increment, where it comes from an internal wrapping pointer.

Parameters:
- DB_COUNT, 50000: cycles a synchronised button level must be stable before it is accepted.
- DB_WIDTH, 16: width of the debounce counter; must satisfy 2^DB_WIDTH > DB_COUNT.
- VAL_WIDTH, 3: width of MemVal.
- NUM_WIDTH, 2: width of MemNum.
- DATA_DEPTH, 4: number of presettable words; the pointer wraps at DATA_DEPTH-1.
- HOLD_CYCLES, 2: cycles MemVal/MemNum are held stable after the strobe.

Ports:
- clk  in  1  system clock, same domain as the SoC.
- rst  in  1  asynchronous, active-low reset.
- btn_load  in  1  raw, asynchronous, bouncy load button.
- btn_next  in  1  raw, asynchronous, bouncy pointer-advance button.
- sw_val  in  VAL_WIDTH  value switches, asynchronous.
- sw_num  in  NUM_WIDTH  index switches, asynchronous; used in manual mode only.
- auto_inc  in  1  mode select, asynchronous; 1 = internal pointer.
- MemSet  out  1  one-cycle write strobe to MEM.
- MemVal  out  VAL_WIDTH  value to write.
- MemNum  out  NUM_WIDTH  word index to write.
- busy  out  1  high while the FSM is outside IDLE.
- ptr  out  NUM_WIDTH  current auto-increment pointer.
- load_count  out  8  number of strobes issued, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - MemSet=0, MemVal=0, MemNum=0, busy=0, ptr=0, load_count=0.
  - FSM=IDLE; debounce counters and debounced levels cleared.
  - Applies immediately, even mid-sequence; MemSet falls without waiting for clk.
- Input conditioning:
  - All five async inputs pass through two-flop synchronisers.
  - Each button has a debouncer. The counter resets whenever the synchronised level differs from the debounced level. When the counter reaches DB_COUNT-1, the debounced level takes the synchronised level and the counter clears.
  - A press event is a 0->1 transition of the debounced level, one cycle wide.
  - Latency from a clean press to its event is 2 sync cycles + DB_COUNT cycles.
- Switches are sampled only in IDLE, on the cycle the load event is seen. Later switch changes do not affect the write in progress.
- FSM states and transitions:
  - IDLE: on a load event, latch MemVal=sw_val and MemNum=(auto_inc ? ptr : sw_num), then go to SETUP. On a next event with auto_inc=1 and no load event, ptr advances (wrapping) and the FSM stays in IDLE. A next event with auto_inc=0 is ignored.
  - SETUP: exactly 1 cycle; MemVal/MemNum stable, MemSet=0. Next state STROBE.
  - STROBE: exactly 1 cycle; MemSet=1. load_count increments, saturating at 255. If the latched mode was auto, ptr advances (wrapping). Next state HOLD.
  - HOLD: HOLD_CYCLES cycles; MemSet=0, operands unchanged. Then go to WAIT_REL.
  - WAIT_REL: stay until the debounced btn_load is 0, then go to IDLE. This gives exactly one strobe per press; holding the button never auto-repeats.
- busy=1 in SETUP, STROBE, HOLD and WAIT_REL.
- Boundary conditions:
  - Simultaneous load and next events in IDLE: load wins and the next event is dropped. The pointer still advances once via STROBE.
  - Any button event while busy=1 is discarded, not queued.
  - Pointer wrap: DATA_DEPTH-1 -> 0, both for next events and for auto strobes.
  - The auto_inc mode is latched per sequence; toggling auto_inc while busy has no effect until the next load.
- MemVal/MemNum keep their last written values in IDLE; they are not cleared between loads.
- Total from a load event to MemSet high: 2 cycles (IDLE->SETUP->STROBE).

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, SETUP, STROBE, HOLD, WAIT_REL (3-bit).
  - Default widths VAL_WIDTH and NUM_WIDTH, shared with the SoC's MemVal/MemNum ports.
- One natural sub-module, btn_debounce: 2-flop synchroniser, debounce counter and rising-edge pulse; instantiated twice.
- Switch synchronisers stay inline.

Test Plan:
- Use DB_COUNT=4 in simulation.
- Reset mid-STROBE: assert rst=0 while MemSet=1 -> MemSet=0 immediately, busy=0, ptr=0, load_count=0; FSM restarts in IDLE.
- Manual load: auto_inc=0, sw_val=3'b101, sw_num=2'd2, clean press of btn_load -> exactly one cycle with MemSet=1, MemVal=5, MemNum=2. The strobe comes 2 cycles after the event and is held 2 cycles after it; load_count=1.
- Bounce rejection: toggle btn_load 0/1 every 2 cycles for 20 cycles, then hold at 1 -> single strobe only after 4 stable cycles. Holding for 100 cycles gives no second strobe; release then press again -> second strobe.
- Auto-increment wrap: auto_inc=1, ptr=0, four loads with sw_val=1,2,3,4 -> MemNum sequence 0,1,2,3; ptr returns to 0 after the fourth load.
- Next-button behaviour: auto_inc=1, press btn_next twice -> ptr=2 with no MemSet. With auto_inc=0, press btn_next -> ptr unchanged.
- Simultaneous and busy events: load and next events on the same cycle at ptr=1 -> one strobe with MemNum=1, then ptr=2. btn_next pressed during HOLD -> ignored, ptr stays 2. Change sw_val during HOLD -> MemVal unchanged.

Source files
------------

// File: rtl/mem_set_loader_pkg.sv
// Shared definitions for the data-memory preset loader.
// Holds the loader FSM state encoding and the default operand widths,
// which match the SoC MEM stage's MemVal/MemNum ports.
package mem_set_loader_pkg;

    localparam int DEF_VAL_WIDTH = 3;
    localparam int DEF_NUM_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

endpackage

// File: rtl/mem_set_loader_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and
// rising-edge detector on the debounced level.
//   clk, rst  : clock, asynchronous active-low reset
//   raw       : raw asynchronous button input
//   level     : debounced button level
//   press     : one-cycle pulse on a 0->1 transition of level
module btn_debounce #(
    parameter int DB_COUNT = 50000,
    parameter int DB_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    logic                s1, s2;
    logic                level_d;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            // Count only while a change is pending; any glitch back to the
            // accepted level restarts the stability window.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_WIDTH'(DB_COUNT - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/mem_set_loader.sv
// Board-side writer for the SoC data-memory preset port. Debounced button
// presses become single MemSet strobes with operands set up one cycle
// before and held HOLD_CYCLES after the strobe.
//   clk, rst         : clock, asynchronous active-low reset
//   btn_load         : raw load button (one strobe per press)
//   btn_next         : raw pointer-advance button (auto mode only)
//   sw_val, sw_num   : value / index switches
//   auto_inc         : 1 = index from internal pointer
//   MemSet/Val/Num   : preset strobe and operands to the MEM stage
//   busy             : FSM outside IDLE
//   ptr              : auto-increment pointer
//   load_count       : saturating count of strobes issued
module mem_set_loader
    import mem_set_loader_pkg::*;
#(
    parameter int DB_COUNT    = 50000,
    parameter int DB_WIDTH    = 16,
    parameter int VAL_WIDTH   = DEF_VAL_WIDTH,
    parameter int NUM_WIDTH   = DEF_NUM_WIDTH,
    parameter int DATA_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_load,
    input  logic                 btn_next,
    input  logic [VAL_WIDTH-1:0] sw_val,
    input  logic [NUM_WIDTH-1:0] sw_num,
    input  logic                 auto_inc,
    output logic                 MemSet,
    output logic [VAL_WIDTH-1:0] MemVal,
    output logic [NUM_WIDTH-1:0] MemNum,
    output logic                 busy,
    output logic [NUM_WIDTH-1:0] ptr,
    output logic [7:0]           load_count
);

    localparam int HC_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic load_lvl, load_ev;
    logic next_lvl, next_ev;

    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_load (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_load),
        .level (load_lvl),
        .press (load_ev)
    );

    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .level (next_lvl),
        .press (next_ev)
    );

    // Switch synchronisers; values only matter on the load-event cycle.
    logic [VAL_WIDTH-1:0] sw_val_m, sw_val_s;
    logic [NUM_WIDTH-1:0] sw_num_m, sw_num_s;
    logic                 auto_m, auto_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_val_m <= '0;
            sw_val_s <= '0;
            sw_num_m <= '0;
            sw_num_s <= '0;
            auto_m   <= 1'b0;
            auto_s   <= 1'b0;
        end else begin
            sw_val_m <= sw_val;
            sw_val_s <= sw_val_m;
            sw_num_m <= sw_num;
            sw_num_s <= sw_num_m;
            auto_m   <= auto_inc;
            auto_s   <= auto_m;
        end
    end

    state_t              state, state_nxt;
    logic                mode_q;
    logic [HC_W-1:0]     hold_cnt;
    logic                hold_done;
    logic [NUM_WIDTH-1:0] ptr_inc;

    assign hold_done = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
    assign ptr_inc   = (ptr == NUM_WIDTH'(DATA_DEPTH - 1)) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (load_ev) state_nxt = ST_SETUP;
            ST_SETUP:    state_nxt = ST_STROBE;
            ST_STROBE:   state_nxt = ST_HOLD;
            ST_HOLD:     if (hold_done) state_nxt = ST_WAIT_REL;
            // Wait for release so a held button never re-triggers.
            ST_WAIT_REL: if (!load_lvl) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops it at once.
    assign MemSet = (state == ST_STROBE);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MemVal     <= '0;
            MemNum     <= '0;
            ptr        <= '0;
            load_count <= '0;
            mode_q     <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
            if (state == ST_IDLE) begin
                // Load takes priority; a coincident next event is dropped.
                if (load_ev) begin
                    MemVal <= sw_val_s;
                    MemNum <= auto_s ? ptr : sw_num_s;
                    mode_q <= auto_s;
                end else if (next_ev && auto_s) begin
                    ptr <= ptr_inc;
                end
            end
            if (state == ST_STROBE) begin
                if (load_count != 8'hFF) load_count <= load_count + 8'd1;
                if (mode_q) ptr <= ptr_inc;
            end
        end
    end

endmodule
